// File: rtl/satd_ctrl.sv
// satd_ctrl: sequencing controller for the 4x8 SATD datapath.
// Accepts ROWS pixel rows over a valid/ready handshake, then walks the
// datapath through drain, COLS vertical-transform passes and a final
// accumulate flush, pulsing done once the accumulator holds the SATD.
module satd_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 8,
  parameter int DRAIN_LAT = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    diff_en,
  output logic [$clog2(ROWS)-1:0] diff_row,
  output logic                    h1_en,
  output logic [$clog2(ROWS)-1:0] h1_row,
  output logic                    t_wr_en,
  output logic [$clog2(ROWS)-1:0] t_row,
  output logic                    v_en,
  output logic [$clog2(COLS)-1:0] v_col,
  output logic                    acc_clr,
  output logic                    acc_en,
  output logic [$clog2(COLS)-1:0] acc_col,
  output logic                    busy,
  output logic                    done
);

  localparam int RW         = $clog2(ROWS);
  localparam int CLW        = $clog2(COLS);
  localparam int CNT_MAX_RC = (ROWS > COLS) ? ROWS : COLS;
  localparam int CNT_MAX    = (CNT_MAX_RC > DRAIN_LAT) ? CNT_MAX_RC : DRAIN_LAT;
  localparam int CW         = $clog2(CNT_MAX);

  localparam logic [CW-1:0] ROW_LAST   = CW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_VERT  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;

  logic            beat_s;
  logic            in_ready_s;
  logic [RW-1:0]   diff_row_s;

  logic            h1_en_r;
  logic [RW-1:0]   h1_row_r;
  logic            t_wr_en_r;
  logic [RW-1:0]   t_row_r;
  logic            v_en_r;
  logic [CLW-1:0]  v_col_r;
  logic            acc_clr_r;
  logic            acc_en_r;
  logic [CLW-1:0]  acc_col_r;
  logic            busy_r;
  logic            done_r;

  logic            v_en_nxt_s;
  logic [CLW-1:0]  v_col_nxt_s;
  logic            acc_clr_nxt_s;
  logic            busy_nxt_s;
  logic            done_nxt_s;

  // State and shared counter register; synchronous reset aborts any block.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; an unknown encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_LOAD: begin
        if (beat_s) begin
          if (cnt_r == ROW_LAST) begin
            state_nxt_s = ST_DRAIN;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_LOAD;
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_LOAD;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_nxt_s = ST_VERT;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_VERT: begin
        if (cnt_r == COL_LAST) begin
          state_nxt_s = ST_FLUSH;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_VERT;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        state_nxt_s = ST_DONE;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: handshake is combinational, the rest are next values
  // for the output registers so they line up with the state they describe.
  always_comb begin
    in_ready_s    = 1'b0;
    beat_s        = 1'b0;
    diff_row_s    = {RW{1'b0}};
    v_en_nxt_s    = 1'b0;
    v_col_nxt_s   = {CLW{1'b0}};
    acc_clr_nxt_s = 1'b0;
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;

    if (state_r == ST_LOAD) begin
      in_ready_s = 1'b1;
      diff_row_s = cnt_r[RW-1:0];
    end else begin
      in_ready_s = 1'b0;
      diff_row_s = {RW{1'b0}};
    end
    beat_s = in_valid & in_ready_s;

    if ((state_r == ST_IDLE) && start) begin
      acc_clr_nxt_s = 1'b1;
    end else begin
      acc_clr_nxt_s = 1'b0;
    end

    if (state_nxt_s == ST_VERT) begin
      v_en_nxt_s  = 1'b1;
      v_col_nxt_s = cnt_nxt_s[CLW-1:0];
    end else begin
      v_en_nxt_s  = 1'b0;
      v_col_nxt_s = {CLW{1'b0}};
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Output registers and the diff->h1->t_buffer / v->acc delay pipelines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      h1_en_r   <= 1'b0;
      h1_row_r  <= {RW{1'b0}};
      t_wr_en_r <= 1'b0;
      t_row_r   <= {RW{1'b0}};
      v_en_r    <= 1'b0;
      v_col_r   <= {CLW{1'b0}};
      acc_clr_r <= 1'b0;
      acc_en_r  <= 1'b0;
      acc_col_r <= {CLW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      h1_en_r   <= beat_s;
      h1_row_r  <= diff_row_s;
      t_wr_en_r <= h1_en_r;
      t_row_r   <= h1_row_r;
      v_en_r    <= v_en_nxt_s;
      v_col_r   <= v_col_nxt_s;
      acc_clr_r <= acc_clr_nxt_s;
      acc_en_r  <= v_en_r;
      acc_col_r <= v_col_r;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign in_ready = in_ready_s;
  assign diff_en  = beat_s;
  assign diff_row = diff_row_s;
  assign h1_en    = h1_en_r;
  assign h1_row   = h1_row_r;
  assign t_wr_en  = t_wr_en_r;
  assign t_row    = t_row_r;
  assign v_en     = v_en_r;
  assign v_col    = v_col_r;
  assign acc_clr  = acc_clr_r;
  assign acc_en   = acc_en_r;
  assign acc_col  = acc_col_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_satd_ctrl.sv
// Bench for satd_ctrl: table of block scenarios; expected strobe events are
// derived from the scenario inputs and queued per output, then popped as the
// DUT raises each strobe.
module tb_satd_ctrl;
  localparam int ROWS      = 4;
  localparam int COLS      = 8;
  localparam int DRAIN_LAT = 2;
  localparam int NOCUT     = 1000;

  logic       CLK = 1'b0;
  logic       RST, start, in_valid;
  logic       in_ready, diff_en, h1_en, t_wr_en, v_en, acc_clr, acc_en, busy, done;
  logic [1:0] diff_row, h1_row, t_row;
  logic [2:0] v_col, acc_col;

  always #5 CLK = ~CLK;

  satd_ctrl #(.ROWS(ROWS), .COLS(COLS), .DRAIN_LAT(DRAIN_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .diff_en(diff_en), .diff_row(diff_row),
    .h1_en(h1_en), .h1_row(h1_row), .t_wr_en(t_wr_en), .t_row(t_row),
    .v_en(v_en), .v_col(v_col), .acc_clr(acc_clr), .acc_en(acc_en),
    .acc_col(acc_col), .busy(busy), .done(done)
  );

  typedef struct { int cyc; int idx; } ev_t;
  ev_t q_diff[$], q_h1[$], q_t[$], q_v[$], q_acc[$], q_clr[$], q_done[$];

  typedef struct {
    string       name;
    logic [63:0] start_m, valid_m, rst_m;
    int          ncyc;
    int          b0, d0, cut0, b1, d1, b2, d2;
    int          z_lo, z_hi;
  } vec_t;

  bit exp_busy[64], exp_ready[64], exp_zero[64];
  int cur_cyc = 0;
  bit mon_en  = 1'b0;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cur_cyc, act, exp);
  endtask

  task automatic push_ev(input int kind, input int c, input int idx, input int cut);
    ev_t e;
    e = '{cyc: c, idx: idx};
    if (c <= cut) begin
      case (kind)
        0: q_diff.push_back(e);
        1: q_h1.push_back(e);
        2: q_t.push_back(e);
        3: q_v.push_back(e);
        4: q_acc.push_back(e);
        5: q_clr.push_back(e);
        6: q_done.push_back(e);
        default: ;
      endcase
    end
  endtask

  // Expected events of one block starting (start=1) in cycle c0.
  task automatic push_block(input int c0, input int done_c, input int cut, input logic [63:0] vm);
    int c, k, vs;
    push_ev(5, c0 + 1, 0, cut);
    c = c0 + 1;
    k = 0;
    while (k < ROWS && c < 64) begin
      if (vm[c]) begin
        push_ev(0, c, k, cut);
        push_ev(1, c + 1, k, cut);
        push_ev(2, c + 2, k, cut);
        k++;
      end
      c++;
    end
    vs = c + DRAIN_LAT;
    for (int j = 0; j < COLS; j++) begin
      push_ev(3, vs + j, j, cut);
      push_ev(4, vs + j + 1, j, cut);
    end
    push_ev(6, done_c, 0, cut);
    for (int i = c0 + 1; i <= done_c && i <= cut && i < 64; i++) exp_busy[i] = 1'b1;
    for (int i = c0 + 1; i < c && i <= cut && i < 64; i++) exp_ready[i] = 1'b1;
  endtask

  task automatic pop_ev(input int kind);
    case (kind)
      0: void'(q_diff.pop_front());
      1: void'(q_h1.pop_front());
      2: void'(q_t.pop_front());
      3: void'(q_v.pop_front());
      4: void'(q_acc.pop_front());
      5: void'(q_clr.pop_front());
      6: void'(q_done.pop_front());
      default: ;
    endcase
  endtask

  // Scoreboard compare of one strobe/index pair against its expected queue.
  task automatic sb(input int kind, input string nm, input logic stb, input int idx);
    ev_t e;
    int  sz;
    case (kind)
      0: sz = q_diff.size();
      1: sz = q_h1.size();
      2: sz = q_t.size();
      3: sz = q_v.size();
      4: sz = q_acc.size();
      5: sz = q_clr.size();
      6: sz = q_done.size();
      default: sz = 0;
    endcase
    e = '{cyc: -1, idx: -1};
    if (sz > 0) begin
      case (kind)
        0: e = q_diff[0];
        1: e = q_h1[0];
        2: e = q_t[0];
        3: e = q_v[0];
        4: e = q_acc[0];
        5: e = q_clr[0];
        6: e = q_done[0];
        default: ;
      endcase
    end
    if (stb) begin
      if (sz == 0) chk({nm, " unexpected strobe"}, 1, 0);
      else begin
        chk({nm, " cycle"}, cur_cyc, e.cyc);
        chk({nm, " index"}, idx, e.idx);
        pop_ev(kind);
      end
    end else if (sz > 0 && e.cyc <= cur_cyc) begin
      chk({nm, " missing strobe"}, 0, 1);
      pop_ev(kind);
    end
  endtask

  // Monitor: sample everything mid-cycle on the falling edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      sb(0, "diff_en",  diff_en, int'(diff_row));
      sb(1, "h1_en",    h1_en,   int'(h1_row));
      sb(2, "t_wr_en",  t_wr_en, int'(t_row));
      sb(3, "v_en",     v_en,    int'(v_col));
      sb(4, "acc_en",   acc_en,  int'(acc_col));
      sb(5, "acc_clr",  acc_clr, 0);
      sb(6, "done",     done,    0);
      chk("busy",     int'(busy),     int'(exp_busy[cur_cyc]));
      chk("in_ready", int'(in_ready), int'(exp_ready[cur_cyc]));
      if (exp_zero[cur_cyc])
        chk("all outputs zero", int'({in_ready, diff_en, diff_row, h1_en, h1_row, t_wr_en, t_row,
                                      v_en, v_col, acc_clr, acc_en, acc_col, busy, done} != 26'd0), 0);
    end
  end

  task automatic run_vec(input vec_t v);
    q_diff.delete(); q_h1.delete(); q_t.delete(); q_v.delete();
    q_acc.delete(); q_clr.delete(); q_done.delete();
    for (int i = 0; i < 64; i++) begin
      exp_busy[i] = 1'b0; exp_ready[i] = 1'b0; exp_zero[i] = 1'b0;
    end
    if (v.b0 >= 0) push_block(v.b0, v.d0, v.cut0, v.valid_m);
    if (v.b1 >= 0) push_block(v.b1, v.d1, NOCUT, v.valid_m);
    if (v.b2 >= 0) push_block(v.b2, v.d2, NOCUT, v.valid_m);
    if (v.z_lo >= 0) for (int i = v.z_lo; i <= v.z_hi; i++) exp_zero[i] = 1'b1;

    @(posedge CLK); #1;
    RST = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    for (int k = 0; k < v.ncyc; k++) begin
      if (k > 0) @(posedge CLK);
      #1;
      cur_cyc  = k;
      RST      = v.rst_m[k];
      start    = v.start_m[k];
      in_valid = v.valid_m[k];
      mon_en   = 1'b1;
    end
    @(posedge CLK);
    mon_en = 1'b0;
    chk({v.name, " pending events"}, q_diff.size() + q_h1.size() + q_t.size() + q_v.size()
        + q_acc.size() + q_clr.size() + q_done.size(), 0);
  endtask

  vec_t vecs[7];
  logic [63:0] all1;

  initial begin
    RST = 1'b1; start = 1'b0; in_valid = 1'b0;
    all1 = {64{1'b1}};
    //          name          start_m               valid_m        rst_m      ncyc b0  d0  cut0   b1  d1  b2  d2  z_lo z_hi
    vecs[0] = '{"reset_idle", 64'd0,                all1,          64'd0,     10,  -1, 0,  NOCUT, -1, 0,  -1, 0,  0,   9};
    vecs[1] = '{"unstalled",  64'd1,                all1,          64'd0,     20,  0,  16, NOCUT, -1, 0,  -1, 0,  -1,  0};
    vecs[2] = '{"stalls",     64'd1,                ~64'hC,        64'd0,     22,  0,  18, NOCUT, -1, 0,  -1, 0,  -1,  0};
    vecs[3] = '{"ignored",    64'h409,              all1,          64'd0,     22,  0,  16, NOCUT, -1, 0,  -1, 0,  -1,  0};
    vecs[4] = '{"abort_vert", 64'h1001,             all1,          64'h100,   32,  0,  16, 8,     12, 28, -1, 0,  9,   11};
    vecs[5] = '{"abort_load", 64'd1,                all1,          64'h4,     10,  0,  16, 2,     -1, 0,  -1, 0,  3,   9};
    vecs[6] = '{"back2back",  (64'd1 << 51) - 64'd1, all1,         64'd0,     56,  0,  16, NOCUT, 17, 33, 34, 50, -1,  0};

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset wins over start/in_valid: all strobes low straight after reset.
    @(posedge CLK); #1;
    RST = 1'b1; start = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst busy",     int'(busy),     0);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst diff_en",  int'(diff_en),  0);
    chk("rst acc_clr",  int'(acc_clr),  0);
    chk("rst done",     int'(done),     0);
    // First cycle after release with start high: LOAD next cycle, acc_clr pulse.
    RST = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("post-rst acc_clr", int'(acc_clr), 1);
    chk("post-rst in_ready", int'(in_ready), 1);
    chk("post-rst diff_en", int'(diff_en), 1);
    @(posedge CLK); #1;
    chk("post-rst acc_clr pulse", int'(acc_clr), 0);
    chk("post-rst diff_row", int'(diff_row), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
